muldiv_iter: RTL and testbench

Iterative unsigned multiply/divide engine for the M-extension path. It sits directly upstream of the control unit. The control unit presents sign-corrected magnitudes on `v1`/`v2` with a one-hot op from `instructions[12:10]`. This block returns a 64-bit result on the same bus the control unit reads as `ALUoutput`. Shift-add multiply and restoring divide take one bit per cycle, behind a start/busy/done handshake.

---
 rtl/muldiv_iter.sv | 132 +++++++++++++
 tb/tb_muldiv_iter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_iter.sv
// Iterative unsigned shift-add multiply / restoring divide, one bit per cycle, start/busy/done handshake.
// Latency XLEN+1 edges from accept to done (zero operands finish at once when MULDIV_ZERO_SKIP_EN is defined); start is ignored while busy.
module muldiv_iter #(
  parameter int XLEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [2:0]          op,
  input  logic [XLEN-1:0]     a,
  input  logic [XLEN-1:0]     b,
  output logic                busy,
  output logic                done,
  output logic [2*XLEN-1:0]   result
);

  localparam int CW = $clog2(XLEN) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   a_q;
  logic [XLEN-1:0]   b_q;
  logic [2*XLEN-1:0] p;
  logic [XLEN:0]     r;
  logic [XLEN-1:0]   q;

  logic              accept;
  logic              last;
  logic [XLEN:0]     sum;
  logic [2*XLEN-1:0] p_nxt;
  logic [XLEN+1:0]   r_sh;
  logic              ge;
  logic [XLEN:0]     diff;
  logic [XLEN:0]     r_nxt;
  logic [XLEN-1:0]   q_nxt;
  logic [2*XLEN-1:0] fin;

  assign accept = (state == S_IDLE) && start &&
                  ((op == 3'b001) || (op == 3'b010) || (op == 3'b100));
  assign last   = (cnt == CW'(XLEN - 1));
  assign busy   = (state == S_RUN) || (state == S_DONE);
  assign done   = (state == S_DONE);

  always_comb begin
    sum   = {1'b0, p[2*XLEN-1:XLEN]} + (p[0] ? {1'b0, a_q} : {(XLEN+1){1'b0}});
    p_nxt = {sum, p[XLEN-1:1]};
    // R never exceeds the divisor, so the top bit of the shifted window only matters for the compare
    r_sh  = {r, q[XLEN-1]};
    ge    = (r_sh >= {2'b00, b_q});
    diff  = r_sh[XLEN:0] - {1'b0, b_q};
    r_nxt = ge ? diff : r_sh[XLEN:0];
    q_nxt = {q[XLEN-2:0], ge};
    case (op_q)
      3'b001:  fin = p_nxt;
      3'b010:  fin = {{XLEN{1'b0}}, q_nxt};
      3'b100:  fin = {{XLEN{1'b0}}, r_nxt[XLEN-1:0]};
      default: fin = '0;
    endcase
  end

`ifdef MULDIV_ZERO_SKIP_EN
  logic              zero_hit;
  logic [2*XLEN-1:0] skip_res;

  always_comb begin
    zero_hit = (a == '0) || (b == '0);
    skip_res = '0;
    if (op == 3'b010 && b == '0)
      skip_res = {{XLEN{1'b0}}, {XLEN{1'b1}}};
    else if (op == 3'b100 && b == '0)
      skip_res = {{XLEN{1'b0}}, a};
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      p      <= '0;
      r      <= '0;
      q      <= '0;
      result <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            a_q  <= a;
            b_q  <= b;
            op_q <= op;
            cnt  <= '0;
            p    <= {{XLEN{1'b0}}, b};
            r    <= '0;
            q    <= a;
`ifdef MULDIV_ZERO_SKIP_EN
            if (zero_hit) begin
              state  <= S_DONE;
              result <= skip_res;
            end else begin
              state  <= S_RUN;
              result <= '0;
            end
`else
            state  <= S_RUN;
            result <= '0;
`endif
          end
        end
        S_RUN: begin
          p   <= p_nxt;
          r   <= r_nxt;
          q   <= q_nxt;
          cnt <= cnt + CW'(1);
          if (last) begin
            state  <= S_DONE;
            result <= fin;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_iter.sv
// Bench for muldiv_iter: arithmetic reference model with per-cycle compare, directed literal cases, randomized traffic.
module tb_muldiv_iter;
  localparam int XLEN = 32;

  logic              clk;
  logic              rst;
  logic              start;
  logic [2:0]        op;
  logic [XLEN-1:0]   a;
  logic [XLEN-1:0]   b;
  logic              busy;
  logic              done;
  logic [2*XLEN-1:0] result;

  int checks   = 0;
  int failures = 0;

  muldiv_iter #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] wx, wy;
    wx = {32'd0, x};
    wy = {32'd0, y};
    case (o)
      3'b001:  return wx * wy;
      3'b010:  return (y == 0) ? 64'h0000_0000_FFFF_FFFF : wx / wy;
      default: return (y == 0) ? wx : wx % wy;
    endcase
  endfunction

  // Edges from acceptance until the cycle in which done is expected.
  function automatic int done_delay(input logic [31:0] x, input logic [31:0] y);
`ifdef MULDIV_ZERO_SKIP_EN
    if (x == 0 || y == 0) return 0;
`endif
    return XLEN;
  endfunction

  // Reference model: tracks only "a request is outstanding and k edges have passed".
  logic        m_busy = 1'b0;
  int          m_k    = 0;
  int          m_d    = 0;
  logic [63:0] m_exp  = '0;
  logic [63:0] m_res  = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy = 1'b0;
      m_k    = 0;
      m_res  = '0;
    end else if (m_busy) begin
      if (m_k == m_d) begin
        m_busy = 1'b0;
      end else begin
        m_k++;
        if (m_k == m_d) m_res = m_exp;
      end
    end else if (start && $onehot(op)) begin
      m_busy = 1'b1;
      m_k    = 0;
      m_d    = done_delay(a, b);
      m_exp  = ref_result(op, a, b);
      m_res  = (m_d == 0) ? m_exp : 64'd0;
    end
  end

  always @(negedge clk) begin
    chk("model_busy",   {63'd0, busy}, {63'd0, m_busy});
    chk("model_done",   {63'd0, done}, {63'd0, m_busy && (m_k == m_d)});
    chk("model_result", result, m_res);
  end

  // Issue one request, measure accept-to-done latency (edges counted inclusive of the accept edge).
  task automatic run_op(input string nm, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [63:0] er, input int el);
    int n;
    @(negedge clk); #1;
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk); #1;
    start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
    n = 0;
    while (done !== 1'b1 && n < 80) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_latency"}, 64'(n + 1), 64'(el));
    chk({nm, "_result"}, result, er);
    @(negedge clk);
    chk({nm, "_busy_after"}, {63'd0, busy}, 64'd0);
    chk({nm, "_done_pulse"}, {63'd0, done}, 64'd0);
  endtask

  int zlat;
  int ndone;
  logic [63:0] seen;

  initial begin
`ifdef MULDIV_ZERO_SKIP_EN
    zlat = 1;
`else
    zlat = 33;
`endif
    rst = 1'b0; start = 1'b0; op = 3'b000; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy",   {63'd0, busy}, 64'd0);
    chk("reset_done",   {63'd0, done}, 64'd0);
    chk("reset_result", result, 64'd0);
    #1 rst = 1'b1;

    run_op("mul_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 33);
    run_op("div_100_7", 3'b010, 32'd100, 32'd7, 64'h0E, 33);
    run_op("rem_100_7", 3'b100, 32'd100, 32'd7, 64'h02, 33);
    run_op("div_by_0", 3'b010, 32'h1234, 32'd0, 64'h0000_0000_FFFF_FFFF, zlat);
    run_op("rem_by_0", 3'b100, 32'h1234, 32'd0, 64'h1234, zlat);
    run_op("mul_zero", 3'b001, 32'd0, 32'hDEAD_BEEF, 64'd0, zlat);

    // Multi-hot op must be rejected.
    @(negedge clk); #1;
    start = 1'b1; op = 3'b011; a = 32'd3; b = 32'd4;
    @(negedge clk);
    chk("invalid_op_busy", {63'd0, busy}, 64'd0);
    #1 start = 1'b0;
    @(negedge clk);
    chk("invalid_op_done", {63'd0, done}, 64'd0);

    // DIV request while a MUL is running is dropped.
    @(negedge clk); #1;
    start = 1'b1; op = 3'b001; a = 32'd5; b = 32'd6;
    @(negedge clk); #1;
    start = 1'b0;
    repeat (9) @(negedge clk);
    #1 start = 1'b1; op = 3'b010; a = 32'd9; b = 32'd3;
    @(negedge clk); #1 start = 1'b0;
    ndone = 0;
    seen  = '0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ndone++;
        seen = result;
      end
    end
    chk("busy_ignore_done_count", 64'(ndone), 64'd1);
    chk("busy_ignore_result", seen, 64'd30);

    // Reset in the middle of a MUL.
    @(negedge clk); #1;
    start = 1'b1; op = 3'b001; a = 32'd1000; b = 32'd1000;
    @(negedge clk); #1;
    start = 1'b0;
    repeat (11) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("midreset_busy",   {63'd0, busy}, 64'd0);
    chk("midreset_done",   {63'd0, done}, 64'd0);
    chk("midreset_result", result, 64'd0);
    @(negedge clk); #1 rst = 1'b1;
    run_op("div_81_9", 3'b010, 32'd81, 32'd9, 64'd9, 33);

    // Random traffic, including starts while busy, invalid ops, zero operands and rare resets.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk); #1;
      rst   = ($urandom_range(0, 699) != 0);
      start = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 4))
        0:       op = 3'b001;
        1:       op = 3'b010;
        2:       op = 3'b100;
        3:       op = 3'b010;
        default: op = 3'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0:       a = '0;
        1:       a = 32'($urandom_range(0, 15));
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 3))
        0:       b = '0;
        1:       b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
    end
    @(negedge clk); #1;
    rst = 1'b1; start = 1'b0;
    repeat (40) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
